// File: rtl/muldiv_sequencer_if.sv
// Bus bundle for the iterative multiply/divide unit: operation request,
// HI/LO move strobes and architectural HI/LO results.
interface muldiv_sequencer_if;
  logic        startInput;
  logic [1:0]  opInput;
  logic [31:0] operandAInput;
  logic [31:0] operandBInput;
  logic        flushInput;
  logic        hiWriteInput;
  logic        loWriteInput;
  logic [31:0] moveDataInput;
  logic [31:0] hiOutput;
  logic [31:0] loOutput;
  logic        busyOutput;
  logic        doneOutput;
  logic        divByZeroOutput;

  modport master (
    output startInput, opInput, operandAInput, operandBInput, flushInput,
           hiWriteInput, loWriteInput, moveDataInput,
    input  hiOutput, loOutput, busyOutput, doneOutput, divByZeroOutput
  );

  modport slave (
    input  startInput, opInput, operandAInput, operandBInput, flushInput,
           hiWriteInput, loWriteInput, moveDataInput,
    output hiOutput, loOutput, busyOutput, doneOutput, divByZeroOutput
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// 32-iteration sequential MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Magnitudes are iterated unsigned; signs are re-applied on the completion edge.
module muldiv_sequencer (
  input  logic                  clk,
  input  logic                  reset,
  muldiv_sequencer_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] m_q, m_d;        // multiplicand or divisor magnitude
  logic [63:0] work_q, work_d;  // {acc, multiplier} or {remainder, quotient}
  logic        neg_q, neg_d;
  logic        rneg_q, rneg_d;
  logic        dbz_q, dbz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        accept;
  logic        in_signed;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_step;
  logic [32:0] rem_sh;
  logic        rem_ge;
  logic [31:0] rem_diff;
  logic [63:0] div_step;
  logic [63:0] prod_res;
  logic [31:0] quot_res, rem_res;

  always_comb begin
    in_signed = ~bus.opInput[0];
    a_neg     = in_signed & bus.operandAInput[31];
    b_neg     = in_signed & bus.operandBInput[31];
    a_mag     = a_neg ? (~bus.operandAInput + 32'd1) : bus.operandAInput;
    b_mag     = b_neg ? (~bus.operandBInput + 32'd1) : bus.operandBInput;
    accept    = (state_q != RUN) && bus.startInput && !bus.flushInput;

    mul_sum   = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, m_q} : 33'd0);
    mul_step  = {mul_sum, work_q[31:1]};

    // Remainder never exceeds the divisor, so the low 32 bits of the difference suffice.
    rem_sh    = work_q[63:31];
    rem_ge    = rem_sh >= {1'b0, m_q};
    rem_diff  = rem_sh[31:0] - m_q;
    div_step  = {(rem_ge ? rem_diff : rem_sh[31:0]), work_q[30:0], rem_ge};

    prod_res  = neg_q  ? (~mul_step + 64'd1) : mul_step;
    quot_res  = neg_q  ? (~div_step[31:0] + 32'd1) : div_step[31:0];
    rem_res   = rneg_q ? (~div_step[63:32] + 32'd1) : div_step[63:32];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    m_d     = m_q;
    work_d  = work_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dbz_d   = dbz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      RUN: begin
        if (bus.flushInput) begin
          state_d = IDLE;
        end else begin
          work_d = op_q[1] ? div_step : mul_step;
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = DONE;
            if (op_q[1]) begin
              hi_d = rem_res;
              lo_d = quot_res;
            end else begin
              hi_d = prod_res[63:32];
              lo_d = prod_res[31:0];
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        if (bus.hiWriteInput) hi_d = bus.moveDataInput;
        if (bus.loWriteInput) lo_d = bus.moveDataInput;
        if (accept) begin
          op_d   = bus.opInput;
          cnt_d  = 5'd0;
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg;
          m_d    = bus.opInput[1] ? b_mag : a_mag;
          work_d = {32'd0, (bus.opInput[1] ? a_mag : b_mag)};
          dbz_d  = bus.opInput[1] && (bus.operandBInput == 32'd0);
          state_d = dbz_d ? DONE : RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 2'd0;
      m_q     <= 32'd0;
      work_q  <= 64'd0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      m_q     <= m_d;
      work_q  <= work_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.hiOutput        = hi_q;
  assign bus.loOutput        = lo_q;
  assign bus.busyOutput      = (state_q == RUN);
  assign bus.doneOutput      = (state_q == DONE);
  assign bus.divByZeroOutput = (state_q == DONE) && dbz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: stimulus pushes expected HI/LO/divByZero
// into a queue; a monitor pops and compares on every done pulse.
module tb_muldiv_sequencer;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];

  muldiv_sequencer_if bus ();

  muldiv_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && bus.doneOutput) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          $display("[TB] %s done: hi=%h lo=%h dbz=%0b", e.name, bus.hiOutput, bus.loOutput,
                   bus.divByZeroOutput);
          check({e.name, "_hi"}, bus.hiOutput, e.hi);
          check({e.name, "_lo"}, bus.loOutput, e.lo);
          check({e.name, "_dbz"}, {31'd0, bus.divByZeroOutput}, {31'd0, e.dbz});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.startInput    = 1'b0;
    bus.flushInput    = 1'b0;
    bus.hiWriteInput  = 1'b0;
    bus.loWriteInput  = 1'b0;
  endtask

  task automatic expect_result(input string name, input logic [31:0] hi,
                               input logic [31:0] lo, input logic dbz);
    exp_t e;
    e.name = name; e.hi = hi; e.lo = lo; e.dbz = dbz;
    exp_q.push_back(e);
  endtask

  // Accept edge happens inside; operands are scrambled afterwards.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.opInput       = op;
    bus.operandAInput = a;
    bus.operandBInput = b;
    bus.startInput    = 1'b1;
    tick();
    bus.startInput    = 1'b0;
    bus.operandAInput = 32'h5A5A_1234;
    bus.operandBInput = 32'hC3C3_0001;
  endtask

  // Counts busy cycles; at cycle inj a start and an MTLO are presented.
  task automatic wait_busy(input string name, input int inj, input logic [31:0] hi_hold);
    int n = 0;
    while (bus.busyOutput && n < 100) begin
      if (n == inj) begin
        bus.startInput    = 1'b1;
        bus.opInput       = 2'b01;
        bus.operandAInput = 32'd9;
        bus.operandBInput = 32'd9;
        bus.loWriteInput  = 1'b1;
        bus.moveDataInput = 32'hBAD0_BAD0;
        check({name, "_hi_hold"}, bus.hiOutput, hi_hold);
      end else begin
        bus.startInput   = 1'b0;
        bus.loWriteInput = 1'b0;
      end
      n++;
      tick();
    end
    idle_inputs();
    check({name, "_busy_cycles"}, n, 32'd32);
    check({name, "_done_level"}, {31'd0, bus.doneOutput}, 32'd1);
    tick();
    check({name, "_back_idle"}, {30'd0, bus.busyOutput, bus.doneOutput}, 32'd0);
  endtask

  task automatic move(input logic hi_w, input logic lo_w, input logic [31:0] d);
    bus.hiWriteInput  = hi_w;
    bus.loWriteInput  = lo_w;
    bus.moveDataInput = d;
    tick();
    bus.hiWriteInput  = 1'b0;
    bus.loWriteInput  = 1'b0;
  endtask

  task automatic abort_test(input string name, input int at_cnt, input bit use_reset);
    move(1'b1, 1'b0, 32'h0000_AAAA);
    move(1'b0, 1'b1, 32'h0000_5555);
    start_op(2'b10, 32'd50, 32'd5);
    for (int i = 0; i < at_cnt; i++) tick();
    check({name, "_busy_before"}, {31'd0, bus.busyOutput}, 32'd1);
    if (use_reset) begin
      reset = 1'b0;
      #1;
      check({name, "_rst_hi"}, bus.hiOutput, 32'd0);
      check({name, "_rst_lo"}, bus.loOutput, 32'd0);
      check({name, "_rst_flags"}, {29'd0, bus.busyOutput, bus.doneOutput, bus.divByZeroOutput}, 32'd0);
      #2;
      reset = 1'b1;
    end else begin
      bus.flushInput = 1'b1;
      tick();
      bus.flushInput = 1'b0;
      check({name, "_hi_kept"}, bus.hiOutput, 32'h0000_AAAA);
      check({name, "_lo_kept"}, bus.loOutput, 32'h0000_5555);
    end
    for (int i = 0; i < 3; i++) begin
      check({name, "_no_busy_done"}, {30'd0, bus.busyOutput, bus.doneOutput}, 32'd0);
      if (i < 2) tick();
    end
  endtask

  initial begin
    idle_inputs();
    bus.opInput       = 2'b00;
    bus.operandAInput = 32'd0;
    bus.operandBInput = 32'd0;
    bus.moveDataInput = 32'd0;
    reset = 1'b0;
    #12;
    check("reset_hi", bus.hiOutput, 32'd0);
    check("reset_lo", bus.loOutput, 32'd0);
    check("reset_flags", {29'd0, bus.busyOutput, bus.doneOutput, bus.divByZeroOutput}, 32'd0);
    reset = 1'b1;
    tick();

    expect_result("mult_neg3x7", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    start_op(2'b00, 32'hFFFF_FFFD, 32'd7);
    wait_busy("mult_neg3x7", -1, 32'd0);

    expect_result("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_busy("multu_max", -1, 32'd0);

    expect_result("mult_neg2xneg3", 32'd0, 32'd6, 1'b0);
    start_op(2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    wait_busy("mult_neg2xneg3", -1, 32'd0);

    expect_result("div_neg7by2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_busy("div_neg7by2", -1, 32'd0);

    expect_result("div_7byneg2", 32'd1, 32'hFFFF_FFFD, 1'b0);
    start_op(2'b10, 32'd7, 32'hFFFF_FFFE);
    wait_busy("div_7byneg2", -1, 32'd0);

    expect_result("divu_by0", 32'd1, 32'hFFFF_FFFD, 1'b1);
    start_op(2'b11, 32'd100, 32'd0);
    check("divu_by0_immediate_done", {30'd0, bus.doneOutput, bus.divByZeroOutput}, 32'd3);
    check("divu_by0_not_busy", {31'd0, bus.busyOutput}, 32'd0);
    tick();

    expect_result("div_min_by_neg1", 32'd0, 32'h8000_0000, 1'b0);
    start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_busy("div_min_by_neg1", -1, 32'd0);

    move(1'b1, 1'b0, 32'h1234_5678);
    expect_result("divu_7by2", 32'd1, 32'd3, 1'b0);
    start_op(2'b11, 32'd7, 32'd2);
    wait_busy("divu_7by2", 5, 32'h1234_5678);

    // MTHI on the accept edge is visible until the result overwrites it.
    bus.hiWriteInput  = 1'b1;
    bus.moveDataInput = 32'h0000_DEAD;
    expect_result("multu_3x5_mthi", 32'd0, 32'd15, 1'b0);
    start_op(2'b01, 32'd3, 32'd5);
    bus.hiWriteInput  = 1'b0;
    check("mthi_with_start", bus.hiOutput, 32'h0000_DEAD);
    wait_busy("multu_3x5_mthi", -1, 32'h0000_DEAD);

    abort_test("flush_c10", 10, 1'b0);
    abort_test("flush_c31", 31, 1'b0);
    expect_result("multu_after_flush", 32'd0, 32'd42, 1'b0);
    start_op(2'b01, 32'd6, 32'd7);
    wait_busy("multu_after_flush", -1, 32'd0);

    abort_test("reset_c20", 20, 1'b1);
    expect_result("mult_after_reset", 32'hFFFF_FFFF, 32'hFFFF_FFF6, 1'b0);
    start_op(2'b00, 32'd5, 32'hFFFF_FFFE);
    wait_busy("mult_after_reset", -1, 32'd0);

    tick();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
